// File: rtl/atm_pkg.sv
// Shared types for the ATM cash path: dispense FSM states and fault codes.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPENSE,
        ST_SETTLE,
        ST_DONE,
        ST_FAULT
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd1;
    localparam logic [1:0] FAULT_OVER    = 2'd2;

endpackage

// File: rtl/dispense_watchdog.sv
// Loadable down-counter that flags a dispense motor running with no note detected.
module dispense_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
    // Loading T-1 makes expiry coincide with the T-th pulse-free edge after the load.
    localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= RELOAD;
        end else if (enable && count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign expired = enable && (count_reg == '0);

endmodule

// File: rtl/note_dispense_counter.sv
// Counts sensor note pulses against a withdrawal request, then watches a settle window for over-dispense.
// Optional lost-note watchdog is built when DISPENSE_TIMEOUT_EN is defined.
module note_dispense_counter
    import atm_pkg::*;
#(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] req_count,
    input  logic             count_flag,
    input  logic             fault_clr,
    output logic             motor_en,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] dispensed
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);

    state_t           state_reg;
    logic [CNT_W-1:0] target_reg;
    logic [SW-1:0]    settle_reg;
    logic [CNT_W-1:0] dispensed_inc;
    logic             wd_expired;

    assign dispensed_inc = dispensed + CNT_W'(1);

`ifdef DISPENSE_TIMEOUT_EN
    logic wd_load;

    // Reload on DISPENSE entry and on every counted note.
    assign wd_load = (state_reg == ST_IDLE && start && req_count != '0) ||
                     (state_reg == ST_DISPENSE && count_flag);

    dispense_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .load    (wd_load),
        .enable  (state_reg == ST_DISPENSE),
        .expired (wd_expired)
    );
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            target_reg <= '0;
            settle_reg <= '0;
            motor_en   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            dispensed  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        target_reg <= req_count;
                        dispensed  <= '0;
                        if (req_count == '0) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ST_DISPENSE;
                            motor_en  <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end

                ST_DISPENSE: begin
                    // A pulse on the expiry cycle is counted instead of faulting.
                    if (count_flag) begin
                        dispensed <= dispensed_inc;
                        if (dispensed_inc == target_reg) begin
                            state_reg  <= ST_SETTLE;
                            motor_en   <= 1'b0;
                            settle_reg <= '0;
                        end
                    end else if (wd_expired) begin
                        state_reg  <= ST_FAULT;
                        motor_en   <= 1'b0;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FAULT_TIMEOUT;
                    end
                end

                ST_SETTLE: begin
                    if (count_flag) begin
                        if (dispensed != '1) begin
                            dispensed <= dispensed_inc;
                        end
                        state_reg  <= ST_FAULT;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FAULT_OVER;
                    end else if (settle_reg == SETTLE_LAST) begin
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        settle_reg <= settle_reg + SW'(1);
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done      <= 1'b0;
                end

                ST_FAULT: begin
                    if (fault_clr) begin
                        state_reg  <= ST_IDLE;
                        fault      <= 1'b0;
                        fault_code <= FAULT_NONE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    motor_en  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_dispense_counter.sv
// Self-checking bench for note_dispense_counter: timestamp-based reference model plus directed and random stimulus.
// Watchdog scenarios run only when DISPENSE_TIMEOUT_EN is defined.
module tb_note_dispense_counter;

    localparam int CNT_W  = 8;
    localparam int SETTLE = 16;
    localparam int TMO    = 20;

    localparam int P_IDLE   = 0;
    localparam int P_DISP   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_DONE   = 3;
    localparam int P_FAULT  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] req_count;
    logic             count_flag;
    logic             fault_clr;
    logic             motor_en;
    logic             busy;
    logic             done;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] dispensed;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model: phase plus timestamps of the last load / target edge.
    int m_phase  = P_IDLE;
    int m_disp   = 0;
    int m_target = 0;
    int m_code   = 0;
    int m_mark   = 0;
    bit m_valid  = 1'b0;

    always #5 clk = ~clk;

    note_dispense_counter #(
        .CNT_W          (CNT_W),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .req_count  (req_count),
        .count_flag (count_flag),
        .fault_clr  (fault_clr),
        .motor_en   (motor_en),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .dispensed  (dispensed)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_phase = P_IDLE;
                m_disp  = 0;
                m_code  = 0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                case (m_phase)
                    P_IDLE: if (start) begin
                        m_target = int'(req_count);
                        m_disp   = 0;
                        m_mark   = cyc;
                        m_phase  = (req_count == 0) ? P_DONE : P_DISP;
                    end
                    P_DISP: begin
                        if (count_flag) begin
                            m_disp++;
                            m_mark = cyc;
                            if (m_disp == m_target) m_phase = P_SETTLE;
                        end else begin
`ifdef DISPENSE_TIMEOUT_EN
                            if (cyc - m_mark == TMO) begin
                                m_phase = P_FAULT;
                                m_code  = 1;
                            end
`endif
                        end
                    end
                    P_SETTLE: begin
                        if (count_flag) begin
                            m_disp  = (m_disp == 255) ? 255 : m_disp + 1;
                            m_code  = 2;
                            m_phase = P_FAULT;
                        end else if (cyc - m_mark == SETTLE + 1) begin
                            m_phase = P_DONE;
                        end
                    end
                    P_DONE:  m_phase = P_IDLE;
                    default: if (fault_clr) begin
                        m_phase = P_IDLE;
                        m_code  = 0;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("motor_en",   int'(motor_en),   int'(m_phase == P_DISP));
            check("busy",       int'(busy),       int'(m_phase == P_DISP || m_phase == P_SETTLE));
            check("done",       int'(done),       int'(m_phase == P_DONE));
            check("fault",      int'(fault),      int'(m_phase == P_FAULT));
            check("fault_code", int'(fault_code), m_code);
            check("dispensed",  int'(dispensed),  m_disp);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse();
        count_flag = 1'b1;
        tick();
        count_flag = 1'b0;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        req_count = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    int n;
    bit prev_flag;
    int rate;

    initial begin
        reset = 1'b1; start = 1'b0; req_count = '0; count_flag = 1'b0; fault_clr = 1'b0;
        idle(3);
        reset = 1'b0;
        check("rst_outputs", int'({motor_en, busy, done, fault, fault_code}), 0);
        check("rst_dispensed", int'(dispensed), 0);
        tick();

        // Three notes, one pulse every 5 cycles.
        do_start(3);
        check("s1_motor_on", int'(motor_en), 1);
        idle(4); pulse(); idle(4); pulse(); idle(4); pulse();
        check("s1_dispensed", int'(dispensed), 3);
        check("s1_motor_off", int'(motor_en), 0);
        wait_done(n);
        check("s1_done_delay", n, 17);
        tick();
        check("s1_done_one_cycle", int'(done), 0);
        check("s1_no_fault", int'(fault), 0);

        // Zero request completes on the next cycle.
        do_start(0);
        check("s2_done", int'(done), 1);
        check("s2_motor", int'(motor_en), 0);
        check("s2_dispensed", int'(dispensed), 0);
        tick();

        // Over-dispense during settle; fault_clr together with start.
        do_start(2);
        idle(2); pulse(); idle(2); pulse();
        idle(3); pulse();
        check("s3_fault", int'(fault), 1);
        check("s3_code", int'(fault_code), 2);
        check("s3_dispensed", int'(dispensed), 3);
        start = 1'b1; req_count = 8'd5; fault_clr = 1'b1;
        tick();
        start = 1'b0; fault_clr = 1'b0;
        check("s3_cleared", int'({fault, fault_code}), 0);
        check("s3_start_ignored", int'(busy), 0);
        tick();
        check("s3_still_idle", int'(busy), 0);

`ifdef DISPENSE_TIMEOUT_EN
        // Silence after one note trips the watchdog after exactly TMO cycles.
        do_start(2);
        pulse();
        n = 0;
        while (!fault && n < 100) begin
            tick();
            n++;
        end
        check("s4_timeout_delay", n, TMO);
        check("s4_code", int'(fault_code), 1);
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        // A pulse on the expiry cycle wins over the watchdog.
        do_start(3);
        pulse(); idle(TMO - 1); pulse();
        check("s4_pulse_wins", int'(fault), 0);
        check("s4_disp", int'(dispensed), 2);
        pulse();
        wait_done(n);
        check("s4_done_disp", int'(dispensed), 3);
        tick();
`endif

        // Reset mid-dispense, then a clean transaction.
        do_start(3);
        idle(2); pulse(); idle(2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("s5_rst_outputs", int'({motor_en, busy, done, fault, fault_code}), 0);
        check("s5_rst_dispensed", int'(dispensed), 0);
        do_start(1);
        idle(1); pulse();
        wait_done(n);
        check("s5_done_delay", n, 17);
        check("s5_dispensed", int'(dispensed), 1);
        tick();

        // Pulses in IDLE and DONE, start while busy.
        pulse(); idle(1); pulse();
        check("s6_idle_pulse", int'(dispensed), 1);
        do_start(2);
        idle(1);
        start = 1'b1; req_count = 8'd7; tick(); start = 1'b0;
        pulse(); idle(1); pulse();
        wait_done(n);
        check("s6_dispensed", int'(dispensed), 2);
        pulse();
        check("s6_done_pulse", int'(dispensed), 2);
        check("s6_idle_after_done", int'(busy), 0);

        // Random traffic at several note rates.
        prev_flag = 1'b0;
        for (int seg = 0; seg < 6; seg++) begin
            rate = (seg % 3 == 0) ? 4 : ((seg % 3 == 1) ? 12 : 40);
            for (int i = 0; i < 500; i++) begin
                start      = ($urandom % 8) == 0;
                req_count  = CNT_W'($urandom % 6);
                count_flag = !prev_flag && (($urandom % rate) == 0);
                prev_flag  = count_flag;
                fault_clr  = ($urandom % 6) == 0;
                reset      = ($urandom % 400) == 0;
                tick();
            end
        end
        start = 1'b0; count_flag = 1'b0; fault_clr = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
